iter_comparer: RTL
==================

ITER_COMPARER -- requirements
Module: iter_comparer

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, operand width in bits.
REQ-002 The block SHALL expose parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be a positive multiple of CHUNK, N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin a comparison.
REQ-006 Signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 NotEqual  output  1  1 when A != B.
REQ-012 LessThan  output  1  1 when A < B under the latched mode.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE; busy SHALL be high only in RUN; done SHALL be high only in DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL latch A, B and Signed, set chunk index to N-1 and enter RUN.
REQ-015 start in RUN SHALL be ignored; changes on A, B or Signed after the latching edge SHALL NOT affect the result.
REQ-016 In RUN, each edge SHALL compare one CHUNK-bit slice of the latched operands, MSB slice first, then descending.
REQ-017 For the top slice with Signed=1, the slice MSB of both operands SHALL be inverted before an unsigned slice compare; all other slices SHALL be compared unsigned.
REQ-018 If slices differ: NotEqual<=1, LessThan<=(slice A < slice B), enter DONE (early termination).
REQ-019 If slices equal and index=0: NotEqual<=0, LessThan<=0, enter DONE; if index>0, decrement index and stay in RUN.
REQ-020 Latency: with k slices examined (1<=k<=N), done SHALL be high in the cycle following the k-th edge after the start-sampling edge.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE unless start=1 (REQ-014).
REQ-022 NotEqual and LessThan SHALL update only at the deciding edge and hold until the next deciding edge or reset.
REQ-023 With CHUNK=WIDTH (N=1), every comparison SHALL complete in exactly one RUN edge.
REQ-024 Result SHALL equal a full-width compare: A=B gives NotEqual=0, LessThan=0 for both modes.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, busy=0, done=0, NotEqual=0, LessThan=0, index=0, latched operands cleared, regardless of clock.
REQ-026 Reset during RUN SHALL abort the comparison; no done pulse for it SHALL ever appear.
REQ-027 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=32, CHUNK=8)
REQ-028 A=0xFFFFFFFF, B=0x00000001, Signed=1, start -> LessThan=1, NotEqual=1, done after 1 RUN edge.
REQ-029 Same operands, Signed=0 -> LessThan=0, NotEqual=1, done after 1 RUN edge.
REQ-030 A=B=0x12345678, either mode -> NotEqual=0, LessThan=0, done after 4 RUN edges, busy high for exactly 4 cycles.
REQ-031 A=0x80000000, B=0x80000001, Signed=1 -> LessThan=1, NotEqual=1 after 4 RUN edges; A/B changed to 0 during RUN -> result unchanged.
REQ-032 rst pulsed mid-RUN (after 2 edges) -> busy=0, outputs 0 immediately, no done; start pulse during RUN produces no second done.
REQ-033 start held high across DONE -> new comparison accepted in DONE cycle; busy high the following cycle, back-to-back done pulses separated by k cycles.

Source files
------------

// File: rtl/iter_comparer.sv
// -----------------------------------------------------------------------------
// iter_comparer
//
// Multi-cycle magnitude comparator. The operands are latched when start is
// accepted. One CHUNK-bit slice is then compared per clock, beginning with the
// most significant slice. The comparison stops at the first slice that differs.
// In two's-complement mode the sign bit of the top slice is flipped, so that an
// unsigned slice compare orders negative values below positive ones.
//
// Parameters
//   WIDTH     operand width in bits (positive multiple of CHUNK)
//   CHUNK     bits compared per cycle
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     request a comparison (accepted in IDLE or DONE, ignored in RUN)
//   Signed    1 = two's-complement compare, 0 = unsigned compare
//   A, B      operands
//   busy      high while a comparison is in progress
//   done      one-cycle pulse when NotEqual/LessThan hold a fresh result
//   NotEqual  A != B
//   LessThan  A <  B under the latched mode
// -----------------------------------------------------------------------------
module iter_comparer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             NotEqual,
    output logic             LessThan
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q,   idx_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             signed_q, signed_d;
    logic             ne_q,    ne_d;
    logic             lt_q,    lt_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;

    // Current slice of the latched operands, with the sign bit flipped on the
    // top slice in signed mode.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
        if (signed_q && (idx_q == TOP_IDX)) begin
            a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
            b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        ne_d     = ne_q;
        lt_d     = lt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    signed_d = Signed;
                    idx_d    = TOP_IDX;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (a_sl != b_sl) begin
                    ne_d    = 1'b1;
                    lt_d    = (a_sl < b_sl);
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    ne_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            ne_q     <= ne_d;
            lt_q     <= lt_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign NotEqual = ne_q;
    assign LessThan = lt_q;

endmodule
